// File: rtl/accumulator_bank.sv
// Multi-channel signed accumulator bank with valid/ready request and result streams,
// optional saturation and per-channel sticky overflow flags.
module accumulator_bank #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter bit SATURATE = 1'b1,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [1:0]          in_op,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_ovf,
    output logic [CHANNELS-1:0] ovf_flags
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc [CHANNELS];

    op_e              op;
    logic             accept;
    logic             ch_ok;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   ext_sum;
    logic             arith_ovf;
    logic [WIDTH-1:0] arith_val;
    logic [WIDTH-1:0] new_val;
    logic             new_ovf;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op       = op_e'(in_op);

    // Datapath: one read-modify-write per cycle, so back-to-back requests need no bypass.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        ch_ok     = (32'(in_ch) < CHANNELS);
        cur       = '0;
        ext_sum   = '0;
        arith_ovf = 1'b0;
        arith_val = '0;
        new_val   = '0;
        new_ovf   = 1'b0;

        if (ch_ok) begin
            cur = acc[in_ch];
        end

        if (op == OP_SUB) begin
            ext_sum = {cur[WIDTH-1], cur} - {in_data[WIDTH-1], in_data};
        end else begin
            ext_sum = {cur[WIDTH-1], cur} + {in_data[WIDTH-1], in_data};
        end

        arith_ovf = ext_sum[WIDTH] ^ ext_sum[WIDTH-1];
        if (arith_ovf && SATURATE) begin
            arith_val = ext_sum[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            arith_val = ext_sum[WIDTH-1:0];
        end

        if (ch_ok) begin
            unique case (op)
                OP_ADD, OP_SUB: begin
                    new_val = arith_val;
                    new_ovf = arith_ovf;
                end
                OP_LOAD:  new_val = in_data;
                OP_CLEAR: new_val = '0;
                default:  new_val = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the accumulator array is reset explicitly because the bank must read 0 after reset.
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf_flags <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                if (ch_ok) begin
                    acc[in_ch] <= new_val;
                    if (op == OP_CLEAR) begin
                        ovf_flags[in_ch] <= 1'b0;
                    end else if (new_ovf) begin
                        ovf_flags[in_ch] <= 1'b1;
                    end
                end
                out_valid <= 1'b1;
                out_ch    <= in_ch;
                out_data  <= new_val;
                out_ovf   <= new_ovf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank: a saturating and a wrapping instance (WIDTH=8,
// CHANNELS=4) driven with identical requests and checked against hand-computed values.
module tb_accumulator_bank;

    localparam int W  = 8;
    localparam int CH = 4;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_ch = '0;
    logic [1:0]    in_op = '0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b1;

    logic          s_in_ready, s_out_valid, s_out_ovf;
    logic [1:0]    s_out_ch;
    logic [W-1:0]  s_out_data;
    logic [CH-1:0] s_flags;

    logic          w_in_ready, w_out_valid, w_out_ovf;
    logic [1:0]    w_out_ch;
    logic [W-1:0]  w_out_data;
    logic [CH-1:0] w_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    accumulator_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ch(in_ch), .in_op(in_op), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch), .out_data(s_out_data),
        .out_ovf(s_out_ovf), .ovf_flags(s_flags)
    );

    accumulator_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_ch(in_ch), .in_op(in_op), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_ch(w_out_ch), .out_data(w_out_data),
        .out_ovf(w_out_ovf), .ovf_flags(w_flags)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one request, let it be accepted on the next edge, sample 1 time unit later.
    task automatic issue(input logic [1:0] ch, input logic [1:0] op, input int data);
        in_valid = 1'b1;
        in_ch    = ch;
        in_op    = op;
        in_data  = W'(data);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_both(input string tag, input logic [1:0] ch,
                              input int sat_val, input int wrap_val,
                              input bit ovf, input logic [CH-1:0] flags);
        check({tag, " sat valid"}, longint'(s_out_valid), 1);
        check({tag, " sat ch"},    longint'(s_out_ch), longint'(ch));
        check({tag, " sat data"},  longint'($signed(s_out_data)), longint'(sat_val));
        check({tag, " sat ovf"},   longint'(s_out_ovf), longint'(ovf));
        check({tag, " sat flags"}, longint'(s_flags), longint'(flags));
        check({tag, " wrap data"}, longint'($signed(w_out_data)), longint'(wrap_val));
        check({tag, " wrap ovf"},  longint'(w_out_ovf), longint'(ovf));
        check({tag, " wrap flags"}, longint'(w_flags), longint'(flags));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"}, longint'(s_out_valid), 0);
        check({tag, " out_ch"},    longint'(s_out_ch), 0);
        check({tag, " out_data"},  longint'(s_out_data), 0);
        check({tag, " out_ovf"},   longint'(s_out_ovf), 0);
        check({tag, " flags"},     longint'(s_flags), 0);
        check({tag, " in_ready"},  longint'(s_in_ready), 1);
        check({tag, " wrap valid"}, longint'(w_out_valid), 0);
    endtask

    initial begin
        // 1: power-up reset, then reset asserted with a request in flight.
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("rst0");
        reset = 1'b1;
        issue(0, LOAD, 50);
        check_both("pre-rst load", 0, 50, 50, 1'b0, 4'b0000);
        in_valid = 1'b1; in_ch = 0; in_op = ADD; in_data = 8'd3;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        check_reset_state("rst1");
        issue(0, ADD, 5);
        check_both("post-rst add", 0, 5, 5, 1'b0, 4'b0000);

        // 2: consecutive-cycle read-modify-write on ch1.
        issue(1, LOAD, 10);
        check_both("ch1 load", 1, 10, 10, 1'b0, 4'b0000);
        issue(1, ADD, 7);
        check_both("ch1 add", 1, 17, 17, 1'b0, 4'b0000);
        issue(1, SUB, 20);
        check_both("ch1 sub", 1, -3, -3, 1'b0, 4'b0000);

        // 3/4: positive and negative overflow, saturating vs wrapping, sticky flag, clear.
        issue(2, LOAD, 127);
        check_both("ch2 load max", 2, 127, 127, 1'b0, 4'b0000);
        issue(2, ADD, 1);
        check_both("ch2 pos ovf", 2, 127, -128, 1'b1, 4'b0100);
        issue(2, LOAD, -128);
        check_both("ch2 load min", 2, -128, -128, 1'b0, 4'b0100);
        issue(2, SUB, 1);
        check_both("ch2 neg ovf", 2, -128, 127, 1'b1, 4'b0100);
        issue(2, ADD, 0);
        check_both("ch2 sticky", 2, -128, 127, 1'b0, 4'b0100);
        issue(2, CLR, 99);
        check_both("ch2 clear", 2, 0, 0, 1'b0, 4'b0000);

        // 5: backpressure with a queued request on ch1 (-3 + 100 = 97, then +1 = 98).
        issue(1, ADD, 100);
        check_both("bp first", 1, 97, 97, 1'b0, 4'b0000);
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = 1; in_op = ADD; in_data = 8'd1;
        #1;
        check("bp in_ready low", longint'(s_in_ready), 0);
        repeat (3) @(posedge clock);
        #1;
        check("bp in_ready held", longint'(s_in_ready), 0);
        check_both("bp stall", 1, 97, 97, 1'b0, 4'b0000);
        out_ready = 1'b1;
        #1;
        check("bp in_ready release", longint'(s_in_ready), 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_both("bp queued", 1, 98, 98, 1'b0, 4'b0000);
        @(posedge clock);
        #1;
        check("bp drained", longint'(s_out_valid), 0);

        // 6: interleaved ch0/ch3 updates leave ch1/ch2 untouched.
        issue(0, CLR, 0);
        check_both("ch0 clear", 0, 0, 0, 1'b0, 4'b0000);
        for (int i = 1; i <= 4; i++) begin
            issue(0, ADD, 1);
            check_both($sformatf("ilv ch0 #%0d", i), 0, i, i, 1'b0, 4'b0000);
            issue(3, ADD, 2);
            check_both($sformatf("ilv ch3 #%0d", i), 3, 2 * i, 2 * i, 1'b0, 4'b0000);
        end
        issue(1, ADD, 0);
        check_both("ch1 untouched", 1, 98, 98, 1'b0, 4'b0000);
        issue(2, ADD, 0);
        check_both("ch2 untouched", 2, 0, 0, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
